mlp_feature_sequencer: RTL and testbench

//  Upstream front-end for the combinational printed-MLP classifier (28-bit feature input, 2-bit class output).

---
 rtl/mlp_feature_sequencer_pkg.sv | 19 +
 rtl/mlp_feature_sequencer_if.sv | 25 ++
 rtl/mlp_feature_sequencer_settle_cnt.sv | 42 ++++
 rtl/mlp_feature_sequencer.sv | 159 +++++++++++++++
 tb/tb_mlp_feature_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_feature_sequencer_pkg.sv
// Shared types and sizes for the printed-MLP feature sequencer.
// Holds the feature/class widths and the sequencer state encoding.
package mlp_io_pkg;

  localparam int N_FEAT     = 7;
  localparam int FEAT_W     = 4;
  localparam int CLS_W      = 2;
  localparam int SETTLE_CYC = 4;

  typedef logic [FEAT_W-1:0] feat_t;
  typedef logic [CLS_W-1:0]  cls_t;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/mlp_feature_sequencer_if.sv
// Feature stream (in) and result stream (out) of the MLP feature sequencer.
// slave is the sequencer side; master is the producer/consumer side.
interface mlp_feature_sequencer_if;
  import mlp_io_pkg::*;

  logic  feat_valid;
  logic  feat_ready;
  feat_t feat_data;
  logic  feat_last;
  logic  res_valid;
  logic  res_ready;
  cls_t  res_cls;
  logic  res_unstable;

  modport master (
    output feat_valid, feat_data, feat_last, res_ready,
    input  feat_ready, res_valid, res_cls, res_unstable
  );

  modport slave (
    input  feat_valid, feat_data, feat_last, res_ready,
    output feat_ready, res_valid, res_cls, res_unstable
  );

endinterface

// File: rtl/mlp_feature_sequencer_settle_cnt.sv
// Loadable down-counter timing the classifier settle window.
// Saturates at zero; zero_o and pre_zero_o decode the registered count.
module mlp_settle_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o,
  output logic             pre_zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o     = (cnt_q == {CNT_W{1'b0}});
  assign pre_zero_o = (cnt_q == CNT_W'(1'b1));

endmodule

// File: rtl/mlp_feature_sequencer.sv
// Packs serial 4-bit features into the MLP input, waits a settle window, registers the class.
// Optional DUAL_SAMPLE_EN adds an early class sample and flags a changed result via res_unstable.
module mlp_feature_sequencer
  import mlp_io_pkg::*;
#(
  parameter int SETTLE_CYC_P = SETTLE_CYC
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mlp_feature_sequencer_if.slave   bus,
  output logic [N_FEAT*FEAT_W-1:0] mlp_inp_o,
  input  cls_t                     mlp_cls_i,
  output logic                     frame_err_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(N_FEAT);
  localparam int CNT_W = $clog2(SETTLE_CYC_P) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC_P - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [N_FEAT*FEAT_W-1:0]   inp_q, inp_d;
  cls_t                       res_cls_q, res_cls_d;
  logic                       res_valid_q, res_valid_d;
  logic                       res_unstable_q, res_unstable_d;
  logic                       frame_err_q, frame_err_d;
  logic                       cnt_load_s, cnt_en_s;
  logic                       cnt_zero_s, cnt_pre_zero_s;
`ifdef DUAL_SAMPLE_EN
  cls_t                       early_q, early_d;
`else
  logic                       unused_pre_zero_s;
  assign unused_pre_zero_s = cnt_pre_zero_s;
`endif

  mlp_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load_s),
    .load_val_i (CNT_LOAD),
    .en_i       (cnt_en_s),
    .zero_o     (cnt_zero_s),
    .pre_zero_o (cnt_pre_zero_s)
  );

  // Next-state and datapath updates for the load/settle/hold sequence.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    inp_d          = inp_q;
    res_cls_d      = res_cls_q;
    res_valid_d    = res_valid_q;
    res_unstable_d = res_unstable_q;
    frame_err_d    = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_en_s       = 1'b0;
`ifdef DUAL_SAMPLE_EN
    early_d        = early_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (bus.feat_valid) begin
          for (int i = 0; i < N_FEAT; i++) begin
            if (idx_q == IDX_W'(i)) begin
              inp_d[i*FEAT_W +: FEAT_W] = bus.feat_data;
            end else begin
              inp_d[i*FEAT_W +: FEAT_W] = inp_q[i*FEAT_W +: FEAT_W];
            end
          end
          // The final slot closes the frame regardless of feat_last.
          if (idx_q == IDX_LAST) begin
            state_d    = S_SETTLE;
            idx_d      = {IDX_W{1'b0}};
            cnt_load_s = 1'b1;
          end else if (bus.feat_last) begin
            frame_err_d = 1'b1;
            idx_d       = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_W'(1'b1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_SETTLE: begin
        cnt_en_s = 1'b1;
        if (cnt_zero_s) begin
          res_cls_d   = mlp_cls_i;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
`ifdef DUAL_SAMPLE_EN
          res_unstable_d = (early_q != mlp_cls_i);
`else
          res_unstable_d = 1'b0;
`endif
        end else begin
`ifdef DUAL_SAMPLE_EN
          if (cnt_pre_zero_s) begin
            early_d = mlp_cls_i;
          end else begin
            early_d = early_q;
          end
`else
          state_d = S_SETTLE;
`endif
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_LOAD;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame or pending result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_LOAD;
      idx_q          <= {IDX_W{1'b0}};
      inp_q          <= {(N_FEAT*FEAT_W){1'b0}};
      res_cls_q      <= {CLS_W{1'b0}};
      res_valid_q    <= 1'b0;
      res_unstable_q <= 1'b0;
      frame_err_q    <= 1'b0;
`ifdef DUAL_SAMPLE_EN
      early_q        <= {CLS_W{1'b0}};
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      inp_q          <= inp_d;
      res_cls_q      <= res_cls_d;
      res_valid_q    <= res_valid_d;
      res_unstable_q <= res_unstable_d;
      frame_err_q    <= frame_err_d;
`ifdef DUAL_SAMPLE_EN
      early_q        <= early_d;
`endif
    end
  end

  assign bus.feat_ready   = (state_q == S_LOAD);
  assign busy_o           = (state_q != S_LOAD);
  assign bus.res_valid    = res_valid_q;
  assign bus.res_cls      = res_cls_q;
  assign bus.res_unstable = res_unstable_q;
  assign mlp_inp_o        = inp_q;
  assign frame_err_o      = frame_err_q;

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Directed bench for mlp_feature_sequencer with a toy classifier stand-in on mlp_cls.
// Works in both builds; the expected res_unstable follows DUAL_SAMPLE_EN.
module tb_mlp_feature_sequencer;
  import mlp_io_pkg::*;

`ifdef DUAL_SAMPLE_EN
  localparam logic EXP_UNSTABLE = 1'b1;
`else
  localparam logic EXP_UNSTABLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] mlp_inp;
  cls_t        mlp_cls;
  logic        frame_err;
  logic        busy;
  logic        cls_force_en;
  cls_t        cls_force;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  mlp_feature_sequencer_if bus();

  // Stand-in classifier: XOR of the low two bits of features 0 and 1.
  assign mlp_cls = cls_force_en ? cls_force : (mlp_inp[1:0] ^ mlp_inp[5:4]);

  mlp_feature_sequencer #(.SETTLE_CYC_P(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .mlp_inp_o   (mlp_inp),
    .mlp_cls_i   (mlp_cls),
    .frame_err_o (frame_err),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; returns in the cycle after the accept.
  task automatic send_beat(input logic [3:0] d, input logic l);
    int n = 0;
    bus.feat_valid = 1'b1;
    bus.feat_data  = d;
    bus.feat_last  = l;
    while (bus.feat_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready", {31'd0, bus.feat_ready}, 32'd1);
    @(negedge clk);
    bus.feat_valid = 1'b0;
    bus.feat_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [27:0] v);
    logic [27:0] t;
    for (int i = 0; i < 7; i++) begin
      t = v >> (4 * i);
      send_beat(t[3:0], (i == 6));
    end
  endtask

  // Cycles from the last accept (cycle 0) to the first cycle showing res_valid.
  task automatic wait_result(output int n);
    n = 1;
    while (bus.res_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int last_hs;
    int hs;
    int acc;
    rst            = 1'b1;
    bus.feat_valid = 1'b0;
    bus.feat_data  = 4'h0;
    bus.feat_last  = 1'b0;
    bus.res_ready  = 1'b0;
    cls_force_en   = 1'b0;
    cls_force      = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_mlp_inp",   {4'd0, mlp_inp}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_cls",   {30'd0, bus.res_cls}, 32'd0);
    chk("rst_unstable",  {31'd0, bus.res_unstable}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_ready",     {31'd0, bus.feat_ready}, 32'd1);

    send_frame(28'h7654321);
    chk("f1_mlp_inp", {4'd0, mlp_inp}, 32'h07654321);
    wait_result(n);
    chk("f1_latency", n, 32'd5);
    chk("f1_res_cls", {30'd0, bus.res_cls}, 32'd3);
    chk("f1_unstable", {31'd0, bus.res_unstable}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("hold_cls",   {30'd0, bus.res_cls}, 32'd3);
      chk("hold_ready", {31'd0, bus.feat_ready}, 32'd0);
      chk("hold_inp",   {4'd0, mlp_inp}, 32'h07654321);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("rel_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rel_ready", {31'd0, bus.feat_ready}, 32'd1);
    chk("rel_busy",  {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rel_single", {31'd0, bus.res_valid}, 32'd0);
    end
    bus.res_ready = 1'b0;

    send_beat(4'h8, 1'b0);
    send_beat(4'h9, 1'b0);
    send_beat(4'hA, 1'b1);
    chk("ferr_pulse", {31'd0, frame_err}, 32'd1);
    chk("ferr_inp",   {4'd0, mlp_inp}, 32'h07654A98);
    @(negedge clk);
    chk("ferr_clear", {31'd0, frame_err}, 32'd0);
    chk("ferr_busy",  {31'd0, busy}, 32'd0);
    send_frame(28'h9ABCDEF);
    chk("f2_mlp_inp", {4'd0, mlp_inp}, 32'h09ABCDEF);
    wait_result(n);
    chk("f2_latency", n, 32'd5);
    chk("f2_res_cls", {30'd0, bus.res_cls}, 32'd1);
    handshake();

    send_frame(28'h1234567);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_mlp_inp",   {4'd0, mlp_inp}, 32'd0);
    chk("mrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mrst_res_cls",   {30'd0, bus.res_cls}, 32'd0);
    chk("mrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("mrst_ready",     {31'd0, bus.feat_ready}, 32'd1);
    chk("mrst_busy",      {31'd0, busy}, 32'd0);
    send_beat(4'h5, 1'b0);
    chk("mrst_bit0", {4'd0, mlp_inp}, 32'h00000005);
    send_beat(4'h6, 1'b0);
    send_beat(4'h7, 1'b0);
    send_beat(4'h8, 1'b0);
    send_beat(4'h9, 1'b0);
    send_beat(4'hA, 1'b0);
    send_beat(4'hB, 1'b1);
    chk("f3_mlp_inp", {4'd0, mlp_inp}, 32'h0BA98765);
    wait_result(n);
    chk("f3_res_cls", {30'd0, bus.res_cls}, 32'd3);
    handshake();

    bus.feat_data  = 4'h5;
    bus.feat_last  = 1'b0;
    bus.feat_valid = 1'b1;
    bus.res_ready  = 1'b1;
    last_hs = -1;
    hs  = 0;
    acc = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      if (cyc != 0) @(negedge clk);
      chk("tp_accept_busy", {31'd0, bus.feat_ready & bus.feat_valid & busy}, 32'd0);
      if (bus.feat_ready && bus.feat_valid) acc++;
      if (bus.res_valid && bus.res_ready) begin
        if (last_hs < 0) chk("tp_first", cyc, 32'd11);
        else chk("tp_period", cyc - last_hs, 32'd12);
        chk("tp_cls", {30'd0, bus.res_cls}, 32'd0);
        last_hs = cyc;
        hs++;
      end
    end
    @(posedge clk);
    #1;
    bus.feat_valid = 1'b0;
    bus.res_ready  = 1'b0;
    @(negedge clk);
    chk("tp_hs_count", hs, 32'd5);
    chk("tp_accepts",  acc, 32'd35);
    chk("tp_idle",     {31'd0, busy}, 32'd0);

    cls_force_en = 1'b1;
    cls_force    = 2'd0;
    send_frame(28'h1111111);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    cls_force = 2'd2;
    @(negedge clk);
    chk("ds_valid",    {31'd0, bus.res_valid}, 32'd1);
    chk("ds_res_cls",  {30'd0, bus.res_cls}, 32'd2);
    chk("ds_unstable", {31'd0, bus.res_unstable}, {31'd0, EXP_UNSTABLE});
    handshake();
    send_frame(28'h2222222);
    wait_result(n);
    chk("ds_const_cls",      {30'd0, bus.res_cls}, 32'd2);
    chk("ds_const_unstable", {31'd0, bus.res_unstable}, 32'd0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
